ram_dp_sync: RTL and testbench

//   Parametrised simple dual-port RAM: one write port, one read port, single clock.

---
 rtl/ram_dp_sync_if.sv | 22 ++
 rtl/ram_dp_sync.sv | 62 ++++++
 tb/tb_ram_dp_sync.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_sync_if.sv
// ram_dp_sync_if: write/read port bundle for ram_dp_sync
interface ram_dp_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_dp_sync.sv
// ram_dp_sync: simple dual-port RAM with registered read, RDW policy, optional output stage and post-reset clear
module ram_dp_sync #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  ram_dp_sync_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy, rd_go, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  // The clear sequencer owns the write port while busy; user strobes are dropped
  always_comb begin
    busy        = state_q == ST_CLEAR;
    rd_go       = bus.rd_en && !busy;
    mem_we      = busy || bus.wr_en;
    mem_waddr   = busy ? clr_addr_q : bus.wr_addr;
    mem_wdata   = busy ? '0 : bus.wr_data;
    rd_word     = (RDW_MODE != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr) ? bus.wr_data : mem[bus.rd_addr];
    clr_addr_d  = busy ? clr_addr_q + ADDR_W'(1) : clr_addr_q;
    state_d     = (busy && &clr_addr_q) ? ST_IDLE : state_q;
    s1_valid_d  = rd_go;
    s1_data_d   = rd_go ? rd_word : s1_data_q;
    out_valid_d = s1_valid_q;
    out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
  end
  always_ff @(posedge clk)
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= CLEAR_ON_RST != 0 ? ST_CLEAR : ST_IDLE;
      clr_addr_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  assign bus.rd_valid = OUT_REG != 0 ? out_valid_q : s1_valid_q;
  assign bus.rd_data  = OUT_REG != 0 ? out_data_q : s1_data_q;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_ram_dp_sync.sv
// tb_ram_dp_sync: four configurations driven in lockstep, checked by a scoreboard against a word-array model
module tb_ram_dp_sync;
  localparam int NC = 4;
  function automatic int dw(input int k); return k == 3 ? 16 : 8; endfunction
  function automatic int aw(input int k); return k == 3 ? 10 : 4; endfunction
  function automatic int rdw(input int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int oreg(input int k); return (k == 1 || k == 3) ? 1 : 0; endfunction
  function automatic int clr(input int k); return k == 2 ? 0 : 1; endfunction
  function automatic logic [15:0] dmask(input int k, input logic [15:0] d);
    return k == 3 ? d : {8'h00, d[7:0]};
  endfunction
  function automatic int amask(input int k, input logic [9:0] a);
    return k == 3 ? int'(a) : int'(a[3:0]);
  endfunction
  typedef struct packed {
    logic [15:0] data;
    logic        known;
    logic [31:0] due;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [9:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data_a [NC];
  logic        rd_valid_a [NC];
  logic        busy_a [NC];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int DW = dw(g);
    localparam int AW = aw(g);
    ram_dp_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    ram_dp_sync #(
      .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(rdw(g)), .OUT_REG(oreg(g)), .CLEAR_ON_RST(clr(g))
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr[AW-1:0];
    assign bus.wr_data    = wr_data[DW-1:0];
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_addr[AW-1:0];
    assign rd_data_a[g]   = 16'(bus.rd_data);
    assign rd_valid_a[g]  = bus.rd_valid;
    assign busy_a[g]      = bus.busy;
  end
  // Reference model: word arrays plus a remaining-clear-cycles count per configuration
  logic [15:0] mem_m [NC][1024];
  bit          known_m [NC][1024];
  int          clr_left [NC];
  exp_t        exp_q [NC][$];
  int unsigned cyc = 0;
  bit          rst_s = 1'b0;
  int          checks = 0, fails = 0;
  always @(posedge clk) begin
    exp_t e;
    int ra, wa;
    cyc++;
    rst_s = rst;
    for (int k = 0; k < NC; k++) begin
      ra = amask(k, rd_addr);
      wa = amask(k, wr_addr);
      if (rst) begin
        exp_q[k].delete();
        clr_left[k] = clr(k) != 0 ? (1 << aw(k)) : 0;
        if (clr(k) != 0)
          for (int a = 0; a < 1024; a++) begin
            mem_m[k][a] = '0;
            known_m[k][a] = 1'b1;
          end
      end else if (clr_left[k] > 0) begin
        clr_left[k]--;
      end else begin
        if (rd_en) begin
          e.data  = mem_m[k][ra];
          e.known = known_m[k][ra];
          if (rdw(k) != 0 && wr_en && wa == ra) begin
            e.data  = dmask(k, wr_data);
            e.known = 1'b1;
          end
          e.due = cyc + oreg(k);
          exp_q[k].push_back(e);
        end
        if (wr_en) begin
          mem_m[k][wa] = dmask(k, wr_data);
          known_m[k][wa] = 1'b1;
        end
      end
    end
  end
  logic [15:0] held [NC];
  bit          held_known [NC];
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    for (int k = 0; k < NC; k++) begin
      exp_busy = clr_left[k] > 0;
      checks++;
      if (busy_a[k] !== exp_busy) begin
        fails++;
        $display("FAIL busy cfg%0d cyc%0d: got %0b expected %0b", k, cyc, busy_a[k], exp_busy);
      end
      if (rst_s) begin
        checks++;
        if (rd_valid_a[k] !== 1'b0 || rd_data_a[k] !== 16'h0) begin
          fails++;
          $display("FAIL reset_out cfg%0d cyc%0d: got valid %0b data %h expected 0/0", k, cyc, rd_valid_a[k], rd_data_a[k]);
        end
        held[k] = '0;
        held_known[k] = 1'b1;
      end else if (rd_valid_a[k]) begin
        checks++;
        if (exp_q[k].size() == 0 || exp_q[k][0].due != cyc) begin
          fails++;
          $display("FAIL unexpected_valid cfg%0d cyc%0d: got rd_valid 1 expected 0", k, cyc);
        end else begin
          e = exp_q[k].pop_front();
          if (e.known) begin
            checks++;
            if (rd_data_a[k] !== e.data) begin
              fails++;
              $display("FAIL read_data cfg%0d cyc%0d: got %h expected %h", k, cyc, rd_data_a[k], e.data);
            end
          end
          held[k] = e.data;
          held_known[k] = e.known;
        end
      end else begin
        if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
          checks++;
          fails++;
          $display("FAIL missing_valid cfg%0d cyc%0d: got rd_valid 0 expected 1", k, cyc);
          void'(exp_q[k].pop_front());
        end
        if (held_known[k]) begin
          checks++;
          if (rd_data_a[k] !== held[k]) begin
            fails++;
            $display("FAIL hold_data cfg%0d cyc%0d: got %h expected %h", k, cyc, rd_data_a[k], held[k]);
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) tick();
  endtask
  task automatic op(input bit we, input logic [9:0] wa, input logic [15:0] wd, input bit re, input logic [9:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask
  function automatic logic [9:0] rnd_addr();
    return $urandom_range(0, 1) != 0 ? 10'($urandom_range(0, 15)) : 10'($urandom);
  endfunction
  task automatic random_ops(input int n);
    logic [9:0] wa, ra;
    repeat (n) begin
      wa = rnd_addr();
      ra = $urandom_range(0, 3) == 0 ? wa : rnd_addr();
      op(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ra);
    end
  endtask
  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(16);
    for (int a = 0; a < 16; a++) op(1'b0, '0, '0, 1'b1, 10'(a));
    idle(1030);
    op(1'b1, 10'd12, 16'd45, 1'b0, '0);
    op(1'b1, 10'd8, 16'd124, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 10'd12);
    op(1'b0, '0, '0, 1'b1, 10'd8);
    idle(3);
    op(1'b1, 10'd5, 16'd7, 1'b0, '0);
    op(1'b1, 10'd5, 16'd99, 1'b1, 10'd5);
    op(1'b0, '0, '0, 1'b1, 10'd5);
    idle(3);
    op(1'b1, 10'd1023, 16'hBEEF, 1'b0, '0);
    op(1'b1, 10'd0, 16'h1234, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 10'd1023);
    op(1'b0, '0, '0, 1'b1, 10'd0);
    op(1'b0, '0, '0, 1'b1, 10'd1);
    op(1'b0, '0, '0, 1'b1, 10'd512);
    op(1'b0, '0, '0, 1'b1, 10'd1022);
    idle(3);
    random_ops(400);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op(1'b1, 10'd2, 16'h00AA, 1'b1, 10'd2);
    idle(16);
    op(1'b0, '0, '0, 1'b1, 10'd2);
    idle(1030);
    op(1'b0, '0, '0, 1'b1, 10'd2);
    idle(3);
    op(1'b1, 10'd3, 16'h003C, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op(1'b0, '0, '0, 1'b1, 10'd3);
    idle(1030);
    op(1'b0, '0, '0, 1'b1, 10'd3);
    random_ops(300);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
